// File: rtl/channel_bias_array.sv
// Adds a per-channel signed bias to every element of an accumulator tile, then applies optional ReLU and saturate/truncate.
// Latency: 2 cycles from input acceptance to o_valid (S1 = biased sum, S2 = post-processed result).
// Backpressure: a stage loads only when the stage below it is empty or is draining, so a full pipe still takes one tile per cycle.
module channel_bias_array #(
  parameter  int ROWS   = 5,
  parameter  int COLS   = 5,
  parameter  int AC_BW  = 24,
  parameter  int B_BW   = 8,
  parameter  int OUT_BW = 25,
  parameter  int NUM_CH = 4,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_bias_we,
  input  logic [CH_W-1:0]              i_bias_addr,
  input  logic [B_BW-1:0]              i_bias_data,
  input  logic                         i_relu_en,
  input  logic                         i_sat_en,
  input  logic                         i_ch_clr,
  input  logic                         i_valid,
  output logic                         o_ready,
  input  logic [AC_BW*ROWS*COLS-1:0]   i_acc_kernel,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [OUT_BW*ROWS*COLS-1:0]  o_acc_bias,
  output logic [CH_W-1:0]              o_ch_idx
);

  localparam int N  = ROWS * COLS;
  localparam int SW = AC_BW + 1;

  // Saturation bounds for an OUT_BW-bit signed result, expressed at the wider sum width.
  localparam logic signed [SW-1:0] SAT_MAX = {{(SW-OUT_BW+1){1'b0}}, {(OUT_BW-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = {{(SW-OUT_BW+1){1'b1}}, {(OUT_BW-1){1'b0}}};

  logic signed [B_BW-1:0] bias_q [NUM_CH];
  logic signed [B_BW-1:0] bias_d [NUM_CH];
  logic [CH_W-1:0]        ch_cnt_q, ch_cnt_d;

  logic                   s1_vld_q, s1_vld_d;
  logic signed [SW-1:0]   s1_sum_q [N];
  logic signed [SW-1:0]   s1_sum_d [N];
  logic [CH_W-1:0]        s1_ch_q, s1_ch_d;

  logic                   s2_vld_q, s2_vld_d;
  logic [OUT_BW*N-1:0]    s2_dat_q, s2_dat_d;
  logic [CH_W-1:0]        s2_ch_q, s2_ch_d;

  logic                   s2_free, s1_free, accept, s1_adv;
  logic signed [B_BW-1:0] bias_cur;

  assign s2_free  = !s2_vld_q || i_ready;
  assign s1_free  = !s1_vld_q || s2_free;
  assign accept   = i_valid && s1_free;
  assign s1_adv   = s1_vld_q && s2_free;
  assign bias_cur = bias_q[ch_cnt_q];

  assign o_ready    = s1_free;
  assign o_valid    = s2_vld_q;
  assign o_acc_bias = s2_dat_q;
  assign o_ch_idx   = s2_ch_q;

  // Bias table writes and the channel counter; out-of-range addresses match no entry and are dropped.
  always_comb begin
    bias_d = bias_q;
    for (int c = 0; c < NUM_CH; c++) begin
      if (i_bias_we && (i_bias_addr == CH_W'(c))) begin
        bias_d[c] = i_bias_data;
      end
    end
    ch_cnt_d = ch_cnt_q;
    if (i_ch_clr) begin
      ch_cnt_d = '0;
    end else if (accept) begin
      ch_cnt_d = (ch_cnt_q == CH_W'(NUM_CH - 1)) ? '0 : ch_cnt_q + 1'b1;
    end
  end

  // S1: widen accumulator and current-channel bias by one bit so the add can never overflow.
  always_comb begin
    logic [AC_BW-1:0] acc;
    s1_vld_d = s1_free ? accept : s1_vld_q;
    s1_ch_d  = accept ? ch_cnt_q : s1_ch_q;
    for (int k = 0; k < N; k++) begin
      acc         = i_acc_kernel[k*AC_BW +: AC_BW];
      s1_sum_d[k] = s1_sum_q[k];
      if (accept) begin
        s1_sum_d[k] = {acc[AC_BW-1], acc} + {{(SW-B_BW){bias_cur[B_BW-1]}}, bias_cur};
      end
    end
  end

  // S2: ReLU, then saturate or truncate to OUT_BW; mode bits are sampled as the tile moves in.
  always_comb begin
    logic signed [SW-1:0] v;
    s2_vld_d = s2_free ? s1_vld_q : s2_vld_q;
    s2_ch_d  = s1_adv ? s1_ch_q : s2_ch_q;
    s2_dat_d = s2_dat_q;
    for (int k = 0; k < N; k++) begin
      v = s1_sum_q[k];
      if (i_relu_en && v[SW-1]) begin
        v = '0;
      end
      if (i_sat_en) begin
        if (v > SAT_MAX) begin
          v = SAT_MAX;
        end else if (v < SAT_MIN) begin
          v = SAT_MIN;
        end
      end
      if (s1_adv) begin
        s2_dat_d[k*OUT_BW +: OUT_BW] = v[OUT_BW-1:0];
      end
    end
  end

  // State registers with synchronous active-low clear of table, counter and both stages.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        bias_q[c] <= '0;
      end
      for (int k = 0; k < N; k++) begin
        s1_sum_q[k] <= '0;
      end
      ch_cnt_q <= '0;
      s1_vld_q <= 1'b0;
      s1_ch_q  <= '0;
      s2_vld_q <= 1'b0;
      s2_dat_q <= '0;
      s2_ch_q  <= '0;
    end else begin
      bias_q   <= bias_d;
      s1_sum_q <= s1_sum_d;
      ch_cnt_q <= ch_cnt_d;
      s1_vld_q <= s1_vld_d;
      s1_ch_q  <= s1_ch_d;
      s2_vld_q <= s2_vld_d;
      s2_dat_q <= s2_dat_d;
      s2_ch_q  <= s2_ch_d;
    end
  end

endmodule

// File: tb/tb_channel_bias_array.sv
// Bench for channel_bias_array: directed tiles, expectations queued at acceptance, monitor compares on output handshake.
// Runs with OUT_BW=8, NUM_CH=4 so saturation and wrap-around cases are reachable with small numbers.
// Hold-stability of the output under backpressure is also watched by the monitor.
module tb_channel_bias_array;

  localparam int R  = 5;
  localparam int C  = 5;
  localparam int N  = R * C;
  localparam int AW = 24;
  localparam int BW = 8;
  localparam int OB = 8;
  localparam int NC = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            i_bias_we = 1'b0;
  logic [1:0]      i_bias_addr = '0;
  logic [BW-1:0]   i_bias_data = '0;
  logic            i_relu_en = 1'b0;
  logic            i_sat_en = 1'b0;
  logic            i_ch_clr = 1'b0;
  logic            i_valid = 1'b0;
  logic            o_ready;
  logic [AW*N-1:0] i_acc_kernel = '0;
  logic            o_valid;
  logic            i_ready = 1'b1;
  logic [OB*N-1:0] o_acc_bias;
  logic [1:0]      o_ch_idx;

  channel_bias_array #(
    .ROWS(R), .COLS(C), .AC_BW(AW), .B_BW(BW), .OUT_BW(OB), .NUM_CH(NC)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_bias_we(i_bias_we), .i_bias_addr(i_bias_addr), .i_bias_data(i_bias_data),
    .i_relu_en(i_relu_en), .i_sat_en(i_sat_en), .i_ch_clr(i_ch_clr),
    .i_valid(i_valid), .o_ready(o_ready), .i_acc_kernel(i_acc_kernel),
    .o_valid(o_valid), .i_ready(i_ready), .o_acc_bias(o_acc_bias), .o_ch_idx(o_ch_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    int base; int step; int bias; int ch; bit relu; bit sat; bit hand_en; int hand;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_acc = 0;
  int   ch_m = 0;
  int   bias_m [NC] = '{0, 0, 0, 0};
  int   last_wait = 0;
  bit   hand_en = 1'b0;
  int   hand_v = 0;

  task automatic chk(input string name, input bit ok, input int got, input int exp_v);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp_v);
    end
  endtask

  function automatic int ref_val(input int v_in, input bit relu, input bit sat);
    int v;
    v = v_in;
    if (relu && v < 0) v = 0;
    if (sat) begin
      if (v > 127) v = 127;
      if (v < -128) v = -128;
    end else begin
      v = v & 255;
      if (v > 127) v = v - 256;
    end
    return v;
  endfunction

  task automatic wr(input int addr, input int data);
    i_bias_we   = 1'b1;
    i_bias_addr = addr[1:0];
    i_bias_data = data[7:0];
    @(posedge clk); #1;
    i_bias_we = 1'b0;
    bias_m[addr] = data;
  endtask

  task automatic clr();
    i_ch_clr = 1'b1;
    @(posedge clk); #1;
    i_ch_clr = 1'b0;
    ch_m = 0;
  endtask

  task automatic set_hand(input int v);
    hand_en = 1'b1;
    hand_v  = v;
  endtask

  // Present one tile (element k = base + step*k), optionally with a same-cycle clear or bias write.
  task automatic send(input int base, input int step, input bit clr_en = 1'b0,
                      input bit we = 1'b0, input int wa = 0, input int wd = 0);
    bit   ok;
    int   n;
    exp_t e;
    for (int k = 0; k < N; k++) i_acc_kernel[k*AW +: AW] = AW'(base + step * k);
    i_valid     = 1'b1;
    i_ch_clr    = clr_en;
    i_bias_we   = we;
    i_bias_addr = wa[1:0];
    i_bias_data = wd[7:0];
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 100) begin
      @(negedge clk);
      ok = o_ready;
      @(posedge clk); #1;
      n++;
    end
    i_valid   = 1'b0;
    i_ch_clr  = 1'b0;
    i_bias_we = 1'b0;
    last_wait = n;
    if (!ok) begin
      chk("accept_timeout", 1'b0, n, 100);
    end else begin
      e.base = base; e.step = step; e.bias = bias_m[ch_m]; e.ch = ch_m;
      e.relu = i_relu_en; e.sat = i_sat_en; e.hand_en = hand_en; e.hand = hand_v;
      q.push_back(e);
      n_acc++;
      ch_m = clr_en ? 0 : (ch_m + 1) % NC;
      if (we) bias_m[wa] = wd;
    end
    hand_en = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", q.size() == 0, q.size(), 0);
  endtask

  // Monitor: compare on each output handshake, and check outputs held across a stall.
  bit              prev_stall = 1'b0;
  logic [OB*N-1:0] prev_dat;
  logic [1:0]      prev_ch;

  always @(negedge clk) begin
    exp_t            e;
    int              bad_k, ev, gv;
    logic signed [OB-1:0] el;
    if (rst_n && prev_stall) begin
      chk("hold_valid", o_valid == 1'b1, int'(o_valid), 1);
      chk("hold_data", o_acc_bias == prev_dat && o_ch_idx == prev_ch, int'(o_ch_idx), int'(prev_ch));
    end
    if (rst_n && o_valid && i_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_output", 1'b0, int'(o_ch_idx), -1);
      end else begin
        e = q.pop_front();
        bad_k = -1; ev = 0; gv = 0;
        for (int k = 0; k < N; k++) begin
          int x;
          el = o_acc_bias[k*OB +: OB];
          x  = e.hand_en ? e.hand : ref_val(e.base + e.step * k + e.bias, e.relu, e.sat);
          if (bad_k < 0 && int'(el) != x) begin
            bad_k = k; ev = x; gv = int'(el);
          end
        end
        chk("tile_data", bad_k < 0, gv, ev);
        chk("ch_idx", int'(o_ch_idx) == e.ch, int'(o_ch_idx), e.ch);
      end
    end
    prev_stall = rst_n && o_valid && !i_ready;
    prev_dat   = o_acc_bias;
    prev_ch    = o_ch_idx;
  end

  initial begin
    int n0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", o_valid == 1'b0, int'(o_valid), 0);
    chk("rst_ch_idx", o_ch_idx == 2'd0, int'(o_ch_idx), 0);
    chk("rst_data", o_acc_bias == '0, int'(o_acc_bias[OB-1:0]), 0);
    rst_n = 1'b1;
    chk("rst_ready", o_ready == 1'b1, int'(o_ready), 1);

    // Basic add with two-cycle latency: 10 + (-3) = 7 on channel 0.
    wr(0, -3);
    set_hand(7);
    send(10, 0);
    chk("latency_s1", o_valid == 1'b0, int'(o_valid), 0);
    @(posedge clk); #1;
    chk("latency_s2", o_valid == 1'b1, int'(o_valid), 1);
    drain();

    // Channel wrap: bias[c]=c, zero tiles, six back to back.
    for (int c = 0; c < NC; c++) wr(c, c);
    clr();
    for (int t = 0; t < 6; t++) begin
      set_hand(t % NC);
      send(0, 0);
      chk("back_to_back", last_wait == 1, last_wait, 1);
    end
    // Varied per-element values to exercise packing and 8-bit wrap (channel 2).
    send(-1000, 97);
    drain();

    // Saturation, ReLU and truncation with bias 10 everywhere.
    for (int c = 0; c < NC; c++) wr(c, 10);
    i_sat_en = 1'b1;
    set_hand(127);  send(200, 0);
    set_hand(-128); send(-200, 0);
    drain();
    i_sat_en = 1'b0; i_relu_en = 1'b1;
    set_hand(0);    send(-200, 0);
    set_hand(-46);  send(200, 0);
    drain();
    i_relu_en = 1'b0;
    set_hand(-46);  send(200, 0);
    drain();

    // Same-cycle bias write and same-cycle channel clear.
    clr();
    wr(0, 0);
    wr(1, 2);
    set_hand(1);  send(1, 0);
    set_hand(6);  send(4, 0, 1'b0, 1'b1, 1, 5);
    set_hand(10); send(0, 0, 1'b1);
    set_hand(3);  send(3, 0);
    set_hand(5);  send(0, 0);
    drain();

    // Backpressure: five stalled cycles with a continuous stream of four tiles.
    i_ready = 1'b0;
    n0 = n_acc;
    fork
      begin
        for (int t = 0; t < 4; t++) send(t + 1, 3);
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        chk("bp_accepted", (n_acc - n0) == 2, n_acc - n0, 2);
        chk("bp_ready_low", o_ready == 1'b0, int'(o_ready), 0);
        chk("bp_valid", o_valid == 1'b1, int'(o_valid), 1);
        i_ready = 1'b1;
      end
    join
    drain();

    // Reset with two tiles in flight.
    i_ready = 1'b0;
    send(7, 0);
    send(8, 0);
    rst_n = 1'b0;
    q.delete();
    ch_m = 0;
    for (int c = 0; c < NC; c++) bias_m[c] = 0;
    @(posedge clk); #1;
    chk("rst_mid_valid", o_valid == 1'b0, int'(o_valid), 0);
    chk("rst_mid_ch", o_ch_idx == 2'd0, int'(o_ch_idx), 0);
    rst_n = 1'b1;
    i_ready = 1'b1;
    chk("rst_mid_ready", o_ready == 1'b1, int'(o_ready), 1);
    set_hand(5);
    send(5, 0);
    repeat (4) @(posedge clk);
    #1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
